// File: rtl/sha2_pkg.sv
// Shared definitions for the SHA-2 message scheduler: FSM states, round counts
// and the sigma rotate/shift amounts selected by word width.
package sha2_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;
  localparam logic [15:0] MASK_FULL = 16'hFFFF;

  function automatic int rounds_for(input int word_w);
    if (word_w == 64) begin
      return ROUNDS_512;
    end else begin
      return ROUNDS_256;
    end
  endfunction

  // k = 0/1 -> the two rotate amounts, k = 2 -> the logical shift amount
  function automatic int sig_amt(input int word_w, input bit is_s1, input int k);
    int code;
    code = ((word_w == 64) ? 6 : 0) + (is_s1 ? 3 : 0) + k;
    case (code)
      0:       return 7;
      1:       return 18;
      2:       return 3;
      3:       return 17;
      4:       return 19;
      5:       return 10;
      6:       return 1;
      7:       return 8;
      8:       return 7;
      9:       return 19;
      10:      return 61;
      11:      return 6;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sha2_sched_sigma.sv
// Combinational small-sigma function of the SHA-2 message schedule:
// ROTR(a) ^ ROTR(b) ^ SHR(c), amounts picked by word width and s0/s1 select.
module sha2_sched_sigma
  import sha2_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter bit IS_S1  = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  localparam int RA = sig_amt(WORD_W, IS_S1, 0);
  localparam int RB = sig_amt(WORD_W, IS_S1, 1);
  localparam int SH = sig_amt(WORD_W, IS_S1, 2);

  assign y = ((x >> RA) | (x << (WORD_W - RA)))
           ^ ((x >> RB) | (x << (WORD_W - RB)))
           ^ (x >> SH);

endmodule

// File: rtl/sha2_msg_sched_gen.sv
// SHA-256/512 message scheduler: 16-word ring loaded in IDLE, then W[0..N-1]
// streamed over valid/ready, with either a single-cycle or a serial adder.
module sha2_msg_sched_gen
  import sha2_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 64,
  parameter int SERIAL_ADD = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              load_valid,
  input  logic [3:0]        load_addr,
  input  logic [WORD_W-1:0] load_data,
  output logic              load_ready,
  input  logic              start,
  output logic              wt_valid,
  input  logic              wt_ready,
  output logic [WORD_W-1:0] wt_data,
  output logic [6:0]        wt_round,
  output logic              busy,
  output logic              done
);

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $fatal(1, "sha2_msg_sched_gen: WORD_W must be 32 or 64");
  end
  if (NUM_ROUNDS != rounds_for(WORD_W)) begin : g_bad_rounds
    $fatal(1, "sha2_msg_sched_gen: NUM_ROUNDS does not match WORD_W");
  end

  localparam bit         SER        = (SERIAL_ADD != 0);
  localparam logic [6:0] LAST_ROUND = 7'(NUM_ROUNDS - 1);

  state_t              state_r, state_nxt_s;
  logic [WORD_W-1:0]   ring_r [16];
  logic [15:0]         mask_r;
  logic                wt_valid_r;
  logic [WORD_W-1:0]   wt_data_r;
  logic [6:0]          wt_round_r;
  logic                done_r;
  logic [1:0]          step_r;

  logic [3:0]          idx_s;
  logic [6:0]          round_inc_s;
  logic                hs_s, last_s, go_s;
  logic [WORD_W-1:0]   s0_in_s, s1_in_s, s0_s, s1_s, next_s;

  assign idx_s       = wt_round_r[3:0];
  assign round_inc_s = wt_round_r + 7'd1;
  assign hs_s        = wt_valid_r & wt_ready & (state_r == RUN);
  assign last_s      = (wt_round_r == LAST_ROUND);
  assign go_s        = start & (mask_r == MASK_FULL) & (state_r == IDLE);

  sha2_sched_sigma #(.WORD_W(WORD_W), .IS_S1(1'b0)) u_s0 (.x(s0_in_s), .y(s0_s));
  sha2_sched_sigma #(.WORD_W(WORD_W), .IS_S1(1'b1)) u_s1 (.x(s1_in_s), .y(s1_s));

  // Slot indices are relative to the round being handed over (parallel) or the
  // round being built (serial); 4-bit arithmetic gives the mod-16 ring wrap.
  if (SER) begin : g_ser
    assign s0_in_s = ring_r[idx_s + 4'd1];
    assign s1_in_s = ring_r[idx_s + 4'd14];

    // One two-input add per step, accumulating into wt_data while it is invalid
    always_comb begin
      next_s = wt_data_r;
      case (step_r)
        2'd0:    next_s = ring_r[idx_s] + s0_s;
        2'd1:    next_s = wt_data_r + ring_r[idx_s + 4'd9];
        2'd2:    next_s = wt_data_r + s1_s;
        default: next_s = wt_data_r;
      endcase
    end
  end else begin : g_par
    assign s0_in_s = ring_r[idx_s + 4'd2];
    assign s1_in_s = ring_r[idx_s - 4'd1];
    assign next_s  = s1_s + ring_r[idx_s - 4'd6] + s0_s + ring_r[idx_s + 4'd1];
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = go_s ? RUN : IDLE;
        RUN:     state_nxt_s = (hs_s && last_s) ? IDLE : RUN;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Ring, load mask and output stream datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        ring_r[i] <= '0;
      end
      mask_r     <= 16'h0000;
      wt_valid_r <= 1'b0;
      wt_data_r  <= '0;
      wt_round_r <= 7'd0;
      done_r     <= 1'b0;
      step_r     <= 2'd0;
    end else if (clear) begin
      mask_r     <= 16'h0000;
      wt_valid_r <= 1'b0;
      done_r     <= 1'b0;
      step_r     <= 2'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (load_valid) begin
            ring_r[load_addr] <= load_data;
            mask_r[load_addr] <= 1'b1;
          end
          if (go_s) begin
            wt_valid_r <= 1'b1;
            wt_round_r <= 7'd0;
            wt_data_r  <= ring_r[4'd0];
          end
        end
        RUN: begin
          if (hs_s) begin
            if (wt_round_r >= 7'd16) begin
              ring_r[idx_s] <= wt_data_r;
            end
            if (last_s) begin
              wt_valid_r <= 1'b0;
              done_r     <= 1'b1;
              mask_r     <= 16'h0000;
            end else begin
              wt_round_r <= round_inc_s;
              if (round_inc_s < 7'd16) begin
                wt_data_r <= ring_r[round_inc_s[3:0]];
              end else if (SER) begin
                wt_valid_r <= 1'b0;
                step_r     <= 2'd0;
              end else begin
                wt_data_r <= next_s;
              end
            end
          end else if (SER && !wt_valid_r) begin
            wt_data_r <= next_s;
            step_r    <= step_r + 2'd1;
            if (step_r == 2'd2) begin
              wt_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          wt_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = (state_r == IDLE);
  assign busy       = (state_r == RUN);
  assign wt_valid   = wt_valid_r;
  assign wt_data    = wt_data_r;
  assign wt_round   = wt_round_r;
  assign done       = done_r;

endmodule

// File: tb/tb_sha2_msg_sched_gen.sv
// Bench for sha2_msg_sched_gen: parallel SHA-256, serial SHA-256 and SHA-512
// instances checked against a textbook W[t] recurrence model.
module tb_sha2_msg_sched_gen;

  logic        clk = 1'b0;
  logic        reset_n, clear, load_valid, wt_ready;
  logic        start_p, start_s, start_w;
  logic [3:0]  load_addr;
  logic [31:0] ld32;
  logic [63:0] ld64;

  logic        p_lr, p_valid, p_busy, p_done;
  logic [31:0] p_data;
  logic [6:0]  p_round;
  logic        s_lr, s_valid, s_busy, s_done;
  logic [31:0] s_data;
  logic [6:0]  s_round;
  logic        w_lr, w_valid, w_busy, w_done;
  logic [63:0] w_data;
  logic [6:0]  w_round;

  int          sel = 0;
  logic        o_valid, o_busy, o_done, o_lr;
  logic [63:0] o_data;
  logic [6:0]  o_round;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] msg [16];
  logic [63:0] ref_w [80];
  logic [63:0] got_w [80];
  logic [6:0]  got_r [80];
  int          hs_cyc [80];
  logic [63:0] stall_d [8];
  logic [6:0]  stall_r [8];
  int          n_got;

  always #5 clk = ~clk;

  sha2_msg_sched_gen #(.WORD_W(32), .NUM_ROUNDS(64), .SERIAL_ADD(0)) u_par (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_valid(load_valid),
    .load_addr(load_addr), .load_data(ld32), .load_ready(p_lr), .start(start_p),
    .wt_valid(p_valid), .wt_ready(wt_ready), .wt_data(p_data), .wt_round(p_round),
    .busy(p_busy), .done(p_done));

  sha2_msg_sched_gen #(.WORD_W(32), .NUM_ROUNDS(64), .SERIAL_ADD(1)) u_ser (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_valid(load_valid),
    .load_addr(load_addr), .load_data(ld32), .load_ready(s_lr), .start(start_s),
    .wt_valid(s_valid), .wt_ready(wt_ready), .wt_data(s_data), .wt_round(s_round),
    .busy(s_busy), .done(s_done));

  sha2_msg_sched_gen #(.WORD_W(64), .NUM_ROUNDS(80), .SERIAL_ADD(0)) u_w64 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .load_valid(load_valid),
    .load_addr(load_addr), .load_data(ld64), .load_ready(w_lr), .start(start_w),
    .wt_valid(w_valid), .wt_ready(wt_ready), .wt_data(w_data), .wt_round(w_round),
    .busy(w_busy), .done(w_done));

  always_comb begin
    case (sel)
      1: begin o_valid = s_valid; o_data = {32'h0, s_data}; o_round = s_round;
               o_busy = s_busy; o_done = s_done; o_lr = s_lr; end
      2: begin o_valid = w_valid; o_data = w_data; o_round = w_round;
               o_busy = w_busy; o_done = w_done; o_lr = w_lr; end
      default: begin o_valid = p_valid; o_data = {32'h0, p_data}; o_round = p_round;
               o_busy = p_busy; o_done = p_done; o_lr = p_lr; end
    endcase
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [31:0] x32;
    x32 = x[31:0];
    if (w == 32) return {32'h0, (x32 >> n) | (x32 << (32 - n))};
    else return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [63:0] lsig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    else return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] lsig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    else return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  task automatic build_ref(input int w, input int nr);
    logic [63:0] m;
    m = (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    for (int t = 0; t < 16; t++) ref_w[t] = msg[t] & m;
    for (int t = 16; t < nr; t++)
      ref_w[t] = (lsig1(ref_w[t-2], w) + ref_w[t-7] + lsig0(ref_w[t-15], w) + ref_w[t-16]) & m;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic rand_msg(input int w);
    for (int i = 0; i < 16; i++)
      msg[i] = (w == 32) ? {32'h0, $urandom} : {$urandom, $urandom};
  endtask

  task automatic abc_msg(input int w);
    for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    msg[0]  = (w == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
    msg[15] = 64'h18;
  endtask

  task automatic load_words(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      load_valid = 1'b1; load_addr = 4'(i); ld32 = msg[i][31:0]; ld64 = msg[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic pulse_start(input int s);
    @(negedge clk);
    start_p = (s == 0); start_s = (s == 1); start_w = (s == 2);
    @(negedge clk);
    start_p = 1'b0; start_s = 1'b0; start_w = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Consumes words from the selected instance, recording what it saw
  task automatic stream(input int nr, input bit rand_rdy, input int stall_at,
                        input int stall_len, input int clear_at);
    int t, cyc, stalled;
    bit rdy, quit;
    t = 0; cyc = 0; stalled = 0; quit = 1'b0;
    while (t < nr && cyc < nr * 8 + 100 && !quit) begin
      rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (t == stall_at && stalled < stall_len) rdy = 1'b0;
      if (o_valid && t == clear_at) begin
        clear = 1'b1; quit = 1'b1;
      end else if (o_valid && rdy) begin
        got_w[t] = o_data; got_r[t] = o_round; hs_cyc[t] = cyc; t++;
      end else if (o_valid && t == stall_at && stalled < 8) begin
        stall_d[stalled] = o_data; stall_r[stalled] = o_round; stalled++;
      end
      wt_ready = rdy;
      @(negedge clk);
      cyc++;
    end
    clear = 1'b0;
    wt_ready = 1'b1;
    n_got = t;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (p_valid !== 1'b0 || p_data !== 32'h0 || p_round !== 7'd0 || p_busy !== 1'b0 ||
        p_done !== 1'b0 || p_lr !== 1'b1 || s_valid !== 1'b0 || s_lr !== 1'b1 ||
        w_valid !== 1'b0 || w_data !== 64'h0 || w_lr !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b/%b/%b lr=%b/%b/%b busy=%b done=%b, required valid=0 lr=1 busy=0 done=0",
               p_valid, s_valid, w_valid, p_lr, s_lr, w_lr, p_busy, p_done);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sha256_abc();
    int bad;
    sel = 0;
    abc_msg(32); build_ref(32, 64);
    load_words(0, 15);
    pulse_start(0);
    checks++;
    if (o_busy !== 1'b1 || o_lr !== 1'b0) begin
      failures++; $display("FAIL abc_busy: busy=%b load_ready=%b, required 1/0", o_busy, o_lr);
    end
    stream(64, 1'b0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i] || got_r[i] !== 7'(i)) bad++;
    checks++;
    if (n_got != 64 || bad != 0) begin
      failures++; $display("FAIL abc_words: got %0d words with %0d wrong, required 64 with 0 wrong", n_got, bad);
    end
    checks++;
    if (got_w[16] !== 64'h6162_6380 || got_w[17] !== 64'h000F_0000 || got_w[63] !== 64'h12B1_EDEB) begin
      failures++; $display("FAIL abc_kat: W16=%h W17=%h W63=%h, required 61626380 000f0000 12b1edeb",
                           got_w[16], got_w[17], got_w[63]);
    end
    bad = 0;
    for (int i = 1; i < 64; i++) if (hs_cyc[i] - hs_cyc[i-1] != 1) bad++;
    checks++;
    if (hs_cyc[0] != 0 || bad != 0) begin
      failures++; $display("FAIL abc_contiguous: first at cycle %0d, %0d gaps, required 0 and 0", hs_cyc[0], bad);
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("FAIL abc_done: done=%b busy=%b, required 1/0", o_done, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0) begin
      failures++; $display("FAIL abc_done_pulse: done=%b on second cycle, required 0", o_done);
    end
  endtask

  task automatic test_serial_abc();
    int bad;
    sel = 1;
    abc_msg(32); build_ref(32, 64);
    load_words(0, 15);
    pulse_start(1);
    stream(64, 1'b0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i] || got_r[i] !== 7'(i)) bad++;
    checks++;
    if (n_got != 64 || bad != 0 || got_w[63] !== 64'h12B1_EDEB) begin
      failures++; $display("FAIL serial_words: got %0d words with %0d wrong, W63=%h, required 64/0/12b1edeb",
                           n_got, bad, got_w[63]);
    end
    bad = 0;
    for (int i = 1; i < 64; i++) if (hs_cyc[i] - hs_cyc[i-1] != ((i >= 16) ? 4 : 1)) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL serial_spacing: %0d rounds off the 1/4-cycle spacing, required 0", bad);
    end
    checks++;
    if (o_done !== 1'b1) begin
      failures++; $display("FAIL serial_done: done=%b, required 1", o_done);
    end
  endtask

  task automatic test_sha512_abc();
    int bad;
    sel = 2;
    abc_msg(64); build_ref(64, 80);
    load_words(0, 15);
    pulse_start(2);
    stream(80, 1'b0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 80; i++) if (got_w[i] !== ref_w[i] || got_r[i] !== 7'(i)) bad++;
    checks++;
    if (n_got != 80 || bad != 0) begin
      failures++; $display("FAIL w64_words: got %0d words with %0d wrong, required 80 with 0 wrong", n_got, bad);
    end
    checks++;
    if (got_w[16] !== 64'h6162_6380_0000_0000 || got_w[17] !== 64'h0003_0000_0000_00C0) begin
      failures++; $display("FAIL w64_kat: W16=%h W17=%h, required 6162638000000000 00030000000000c0",
                           got_w[16], got_w[17]);
    end
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      failures++; $display("FAIL w64_done: done=%b busy=%b, required 1/0", o_done, o_busy);
    end
  endtask

  task automatic test_partial_load();
    int bad;
    sel = 0;
    pulse_clear();
    rand_msg(32); build_ref(32, 64);
    load_words(0, 14);
    pulse_start(0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
        failures++; $display("FAIL partial_ignored: valid=%b busy=%b, required 0/0", o_valid, o_busy);
      end
      @(negedge clk);
    end
    load_words(15, 15);
    pulse_start(0);
    checks++;
    if (o_valid !== 1'b1 || o_round !== 7'd0 || o_data !== msg[0]) begin
      failures++; $display("FAIL partial_start: valid=%b round=%0d data=%h, required 1/0/%h",
                           o_valid, o_round, o_data, msg[0]);
    end
    stream(64, 1'b0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i]) bad++;
    checks++;
    if (n_got != 64 || bad != 0) begin
      failures++; $display("FAIL partial_words: got %0d words with %0d wrong, required 64 with 0 wrong", n_got, bad);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    sel = 0;
    rand_msg(32); build_ref(32, 64);
    load_words(0, 15);
    pulse_start(0);
    stream(64, 1'b0, 20, 5, -1);
    bad = 0;
    for (int k = 0; k < 5; k++) if (stall_d[k] !== ref_w[20] || stall_r[k] !== 7'd20) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL bp_hold: %0d stalled cycles unstable, required 0 (W20=%h)", bad, ref_w[20]);
    end
    checks++;
    if (got_w[21] !== ref_w[21] || hs_cyc[20] - hs_cyc[19] != 6 || hs_cyc[21] - hs_cyc[20] != 1) begin
      failures++; $display("FAIL bp_resume: W21=%h gaps %0d/%0d, required %h 6/1",
                           got_w[21], hs_cyc[20] - hs_cyc[19], hs_cyc[21] - hs_cyc[20], ref_w[21]);
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i]) bad++;
    checks++;
    if (n_got != 64 || bad != 0) begin
      failures++; $display("FAIL bp_words: got %0d words with %0d wrong, required 64 with 0 wrong", n_got, bad);
    end
  endtask

  task automatic test_clear();
    int bad;
    sel = 0;
    rand_msg(32);
    load_words(0, 15);
    pulse_start(0);
    stream(64, 1'b0, -1, 0, 30);
    checks++;
    if (n_got != 30 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_lr !== 1'b1 || o_done !== 1'b0) begin
      failures++; $display("FAIL clear_abort: words=%0d valid=%b busy=%b lr=%b done=%b, required 30/0/0/1/0",
                           n_got, o_valid, o_busy, o_lr, o_done);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL clear_quiet: %0d cycles with done/valid after clear, required 0", bad);
    end
    rand_msg(32); build_ref(32, 64);
    load_words(0, 15);
    pulse_start(0);
    checks++;
    if (o_valid !== 1'b1 || o_round !== 7'd0) begin
      failures++; $display("FAIL clear_restart: valid=%b round=%0d, required 1/0", o_valid, o_round);
    end
    stream(64, 1'b0, -1, 0, -1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i]) bad++;
    checks++;
    if (n_got != 64 || bad != 0) begin
      failures++; $display("FAIL clear_rerun: got %0d words with %0d wrong, required 64 with 0 wrong", n_got, bad);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    sel = 1;
    for (int b = 0; b < 2; b++) begin
      rand_msg(32); build_ref(32, 64);
      load_words(0, 15);
      pulse_start(1);
      stream(64, 1'b1, -1, 0, -1);
      bad = 0;
      for (int i = 0; i < 64; i++) if (got_w[i] !== ref_w[i] || got_r[i] !== 7'(i)) bad++;
      checks++;
      if (n_got != 64 || bad != 0 || o_done !== 1'b1) begin
        failures++; $display("FAIL b2b_block%0d: got %0d words with %0d wrong, done=%b, required 64/0/1",
                             b, n_got, bad, o_done);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    sel = 0;
    rand_msg(32);
    load_words(0, 15);
    pulse_start(0);
    wt_ready = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 64'h0 || o_round !== 7'd0 || o_busy !== 1'b0 ||
        o_done !== 1'b0 || o_lr !== 1'b1) begin
      failures++; $display("FAIL reset_mid: valid=%b data=%h round=%0d busy=%b done=%b lr=%b, required 0/0/0/0/0/1",
                           o_valid, o_data, o_round, o_busy, o_done, o_lr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done !== 1'b0 || o_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL reset_mid_quiet: %0d cycles with done/valid after reset, required 0", bad);
    end
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; load_valid = 1'b0; load_addr = 4'd0;
    ld32 = 32'h0; ld64 = 64'h0; wt_ready = 1'b1;
    start_p = 1'b0; start_s = 1'b0; start_w = 1'b0;
    test_reset();
    test_sha256_abc();
    test_serial_abc();
    test_sha512_abc();
    test_partial_load();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
